// File: rtl/bit_cmd_pkg.sv
// bit_cmd_pkg: shared types and helpers for the bit-command debounce front-end
package bit_cmd_pkg;
  localparam int BIT_IDX_W = 3;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} dbnc_state_t;
  typedef struct packed {
    logic [BIT_IDX_W-1:0] index;
    logic                 value;
  } bit_cmd_t;
  function automatic int max_i(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic 2-flop synchroniser, clears to 0 on reset
//   clk, reset : clock, synchronous active-high reset
//   d          : asynchronous input bus
//   q          : synchronised output bus
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clk)
    if (reset) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/bit_cmd_debounce.sv
// bit_cmd_debounce: synchronise and debounce a push-button into single-cycle bit commands
//   clk, reset         : clock, synchronous active-high reset
//   btn_raw            : bouncing push-button, 1 = pressed
//   sw_index, sw_value : bit-select and bit-value switches
//   bit_index/value    : command captured on each strobe
//   valid_out          : one-cycle command strobe
//   AUTO_REPEAT_EN     : when defined, a held button re-issues a command every REPEAT_CYCLES
module bit_cmd_debounce
  import bit_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_CYCLES   = 25_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_raw,
  input  logic [BIT_IDX_W-1:0] sw_index,
  input  logic                 sw_value,
  output logic [BIT_IDX_W-1:0] bit_index,
  output logic                 bit_value,
  output logic                 valid_out
);
  localparam int CNT_W = $clog2(max_i(DEBOUNCE_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic        btn_s;
  bit_cmd_t    sw_s, cmd;
  dbnc_state_t state;
  logic [CNT_W-1:0] cnt;
  sync_2ff #(.WIDTH(1)) u_btn_sync (.clk(clk), .reset(reset), .d(btn_raw), .q(btn_s));
  sync_2ff #(.WIDTH(BIT_IDX_W + 1)) u_sw_sync (.clk(clk), .reset(reset), .d({sw_index, sw_value}), .q(sw_s));
  assign bit_index = cmd.index;
  assign bit_value = cmd.value;
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rcnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rcnt      <= '0;
      cmd       <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE:
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        PRESS_WAIT:
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == D_LAST) begin
            state     <= HELD;
            cmd       <= sw_s;
            valid_out <= 1'b1;
            rcnt      <= '0;
          end else cnt <= cnt + 1'b1;
        HELD:
          if (!btn_s) begin
            state <= REL_WAIT;
            cnt   <= '0;
          end else if (rcnt == R_LAST) begin
            cmd       <= sw_s;
            valid_out <= 1'b1;
            rcnt      <= '0;
          end else rcnt <= rcnt + 1'b1;
        REL_WAIT:
          if (btn_s) begin
            state <= HELD;
            rcnt  <= '0;
          end else if (cnt == D_LAST) state <= IDLE;
          else cnt <= cnt + 1'b1;
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd       <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE:
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        PRESS_WAIT:
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == D_LAST) begin
            state     <= HELD;
            cmd       <= sw_s;
            valid_out <= 1'b1;
          end else cnt <= cnt + 1'b1;
        HELD:
          if (!btn_s) begin
            state <= REL_WAIT;
            cnt   <= '0;
          end
        REL_WAIT:
          if (btn_s) state <= HELD;
          else if (cnt == D_LAST) state <= IDLE;
          else cnt <= cnt + 1'b1;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_bit_cmd_debounce.sv
// tb_bit_cmd_debounce: cycle-exact vector bench for bit_cmd_debounce
module tb_bit_cmd_debounce;
  logic       clk, reset, btn_raw, sw_value, bit_value, valid_out;
  logic [2:0] sw_index, bit_index;
  int errors = 0, checks = 0;
  typedef struct {
    string      tag;
    logic       rst, btn;
    logic [2:0] idx;
    logic       val, ev;
    logic [2:0] ei;
    logic       evl;
  } vec_t;
  vec_t q[$];
  bit_cmd_debounce #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(6)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_index(sw_index), .sw_value(sw_value),
    .bit_index(bit_index), .bit_value(bit_value), .valid_out(valid_out)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic add(input string tag, input logic rst, btn, input logic [2:0] idx, input logic val,
                     input logic ev, input logic [2:0] ei, input logic evl, input int n);
    for (int i = 0; i < n; i++) q.push_back('{tag, rst, btn, idx, val, ev, ei, evl});
  endtask
  task automatic chk(input string tag, input int i, input logic ev, input logic [2:0] ei, input logic evl);
    checks++;
    if ({valid_out, bit_index, bit_value} !== {ev, ei, evl}) begin
      errors++;
      $display("FAIL %s vec %0d: got valid=%b idx=%0d val=%b, want valid=%b idx=%0d val=%b",
               tag, i, valid_out, bit_index, bit_value, ev, ei, evl);
    end
  endtask
  initial begin
    reset = 1; btn_raw = 0; sw_index = 0; sw_value = 0;
`ifdef AUTO_REPEAT_EN
    add("rst",      1, 0, 0, 0, 0, 0, 0, 2);
    add("rep_wait", 0, 1, 1, 1, 0, 0, 0, 6);
    add("rep_p1",   0, 1, 1, 1, 1, 1, 1, 1);
    add("rep_hold", 0, 1, 1, 1, 0, 1, 1, 2);
    add("rep_sw",   0, 1, 6, 1, 0, 1, 1, 3);
    add("rep_p2",   0, 1, 6, 1, 1, 6, 1, 1);
    add("rep_hold", 0, 1, 6, 1, 0, 6, 1, 5);
    add("rep_p3",   0, 1, 6, 1, 1, 6, 1, 1);
    add("rep_hold", 0, 1, 6, 1, 0, 6, 1, 5);
    add("rep_p4",   0, 1, 6, 1, 1, 6, 1, 1);
    add("rep_hold", 0, 1, 6, 1, 0, 6, 1, 5);
    add("rep_p5",   0, 0, 6, 1, 1, 6, 1, 1);
    add("rep_rel",  0, 0, 6, 1, 0, 6, 1, 7);
`else
    add("rst",       1, 1, 5, 1, 0, 0, 0, 3);
    add("press_dly", 0, 1, 5, 1, 0, 0, 0, 6);
    add("press_p",   0, 1, 5, 1, 1, 5, 1, 1);
    add("press_hld", 0, 1, 5, 1, 0, 5, 1, 4);
    add("press_sw",  0, 1, 7, 1, 0, 5, 1, 9);
    add("release",   0, 0, 7, 1, 0, 5, 1, 8);
    for (int i = 0; i < 5; i++) begin
      add("glitch_hi", 0, 1, 7, 1, 0, 5, 1, 2);
      add("glitch_lo", 0, 0, 7, 1, 0, 5, 1, 2);
    end
    add("glitch_end", 0, 0, 7, 1, 0, 5, 1, 6);
    add("b1_dly",    0, 1, 6, 0, 0, 5, 1, 6);
    add("b1_p",      0, 1, 6, 0, 1, 6, 0, 1);
    add("b1_hld",    0, 1, 6, 0, 0, 6, 0, 3);
    add("b1_rel",    0, 0, 6, 0, 0, 6, 0, 2);
    add("b1_bounce", 0, 1, 6, 0, 0, 6, 0, 2);
    add("b1_rel2",   0, 0, 6, 0, 0, 6, 0, 10);
    add("b2_dly",    0, 1, 2, 1, 0, 6, 0, 6);
    add("b2_p",      0, 1, 2, 1, 1, 2, 1, 1);
    add("b2_hld",    0, 1, 2, 1, 0, 2, 1, 3);
    add("b2_rel",    0, 0, 2, 1, 0, 2, 1, 8);
    add("h_dly",     0, 1, 3, 0, 0, 2, 1, 6);
    add("h_p",       0, 1, 3, 0, 1, 3, 0, 1);
    add("h_hld",     0, 1, 3, 0, 0, 3, 0, 1);
    add("h_sw7",     0, 1, 7, 0, 0, 3, 0, 8);
    add("h_rel",     0, 0, 7, 0, 0, 3, 0, 8);
    add("h2_dly",    0, 1, 7, 0, 0, 3, 0, 6);
    add("h2_p",      0, 1, 7, 0, 1, 7, 0, 1);
    add("h2_hld",    0, 1, 7, 0, 0, 7, 0, 3);
    add("h2_rel",    0, 0, 7, 0, 0, 7, 0, 8);
    add("r_dly",     0, 1, 4, 1, 0, 7, 0, 5);
    add("r_reset",   1, 1, 4, 1, 0, 0, 0, 2);
    add("r_dly2",    0, 1, 4, 1, 0, 0, 0, 6);
    add("r_p",       0, 1, 4, 1, 1, 4, 1, 1);
    add("r_hld",     0, 1, 4, 1, 0, 4, 1, 3);
    add("r_rel",     0, 0, 4, 1, 0, 4, 1, 8);
`endif
    @(posedge clk);
    #1;
    chk("rst_state", -1, 0, 0, 0);
    foreach (q[i]) begin
      @(negedge clk);
      reset = q[i].rst; btn_raw = q[i].btn; sw_index = q[i].idx; sw_value = q[i].val;
      @(posedge clk);
      #1;
      chk(q[i].tag, i, q[i].ev, q[i].ei, q[i].evl);
    end
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("wait_expired", q.size(), 0, q[q.size()-1].ei, q[q.size()-1].evl);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
